// File: rtl/cache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped write-back data cache.
// Word helpers select a 32-bit word within a 256-bit line.
package cache_pkg;

  localparam int LINES  = 16;
  localparam int LINE_W = 256;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int OFF_W  = 5;
  localparam int IDX_W  = 4;
  localparam int TAG_W  = 23;
  localparam int WSEL_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cacheState_e;

  function automatic logic [WORD_W-1:0] getWord(input logic [LINE_W-1:0] line,
                                                input logic [WSEL_W-1:0] sel);
    return line[{sel, 5'b00000} +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] putWord(input logic [LINE_W-1:0] line,
                                                input logic [WSEL_W-1:0] sel,
                                                input logic [WORD_W-1:0] word);
    logic [LINE_W-1:0] merged;
    merged = line;
    merged[{sel, 5'b00000} +: WORD_W] = word;
    return merged;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data storage for the data cache: one asynchronous read port, one write port.
// Only valid and dirty are reset; tags and data are don't-care while a line is invalid.
module dcache_line_store
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rdIdx,
  output logic              rdValid,
  output logic              rdDirty,
  output logic [TAG_W-1:0]  rdTag,
  output logic [LINE_W-1:0] rdLine,
  input  logic              wrEn,
  input  logic [IDX_W-1:0]  wrIdx,
  input  logic [TAG_W-1:0]  wrTag,
  input  logic [LINE_W-1:0] wrLine,
  input  logic              wrDirty
);

  logic [LINES-1:0]  validBits;
  logic [LINES-1:0]  dirtyBits;
  logic [TAG_W-1:0]  tagMem  [LINES];
  logic [LINE_W-1:0] lineMem [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validBits <= '0;
      dirtyBits <= '0;
    end else if (wrEn) begin
      validBits[wrIdx] <= 1'b1;
      dirtyBits[wrIdx] <= wrDirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      tagMem[wrIdx]  <= wrTag;
      lineMem[wrIdx] <= wrLine;
    end
  end

  assign rdValid = validBits[rdIdx];
  assign rdDirty = dirtyBits[rdIdx];
  assign rdTag   = tagMem[rdIdx];
  assign rdLine  = lineMem[rdIdx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller (16 x 256-bit lines).
// Hits are served combinationally in IDLE; misses run WRITEBACK (if dirty) then ALLOCATE.
module dcache_controller
  import cache_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_wr_i,
  input  logic [31:0]   cpu_addr_i,
  input  logic [31:0]   cpu_data_i,
  output logic [31:0]   cpu_data_o,
  output logic          cpu_stall_o,
  output logic          mem_req_o,
  output logic          mem_wr_o,
  output logic [31:0]   mem_addr_o,
  output logic [255:0]  mem_data_o,
  input  logic [255:0]  mem_data_i,
  input  logic          mem_ack_i
);

  cacheState_e state, stateNext;

  logic [TAG_W-1:0]  cpuTag;
  logic [IDX_W-1:0]  cpuIdx;
  logic [WSEL_W-1:0] cpuWord;
  logic [1:0]        unusedAddrBits;

  logic [TAG_W-1:0]  missTag;
  logic [IDX_W-1:0]  missIdx;

  logic              rdValid, rdDirty;
  logic [TAG_W-1:0]  rdTag;
  logic [LINE_W-1:0] rdLine;
  logic [IDX_W-1:0]  rdIdx;

  logic              wrEn, wrDirty;
  logic [IDX_W-1:0]  wrIdx;
  logic [TAG_W-1:0]  wrTag;
  logic [LINE_W-1:0] wrLine;

  logic              idleHit;

  assign cpuTag         = cpu_addr_i[31:9];
  assign cpuIdx         = cpu_addr_i[8:5];
  assign cpuWord        = cpu_addr_i[4:2];
  assign unusedAddrBits = cpu_addr_i[1:0];

  // Outside IDLE the store is addressed by the latched miss, so a dropped request still completes.
  assign rdIdx   = (state == IDLE) ? cpuIdx : missIdx;
  assign idleHit = (state == IDLE) && rdValid && (rdTag == cpuTag);

  assign cpu_stall_o = cpu_req_i && !idleHit;

  dcache_line_store u_store (
    .clk     (clk_i),
    .rst     (rst_i),
    .rdIdx   (rdIdx),
    .rdValid (rdValid),
    .rdDirty (rdDirty),
    .rdTag   (rdTag),
    .rdLine  (rdLine),
    .wrEn    (wrEn),
    .wrIdx   (wrIdx),
    .wrTag   (wrTag),
    .wrLine  (wrLine),
    .wrDirty (wrDirty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk_i) begin
    if (state == IDLE && cpu_req_i && !idleHit) begin
      missTag <= cpuTag;
      missIdx <= cpuIdx;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (cpu_req_i && !idleHit)
          stateNext = (rdValid && rdDirty) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: if (mem_ack_i) stateNext = ALLOCATE;
      ALLOCATE:  if (mem_ack_i) stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o  = 1'b0;
    mem_wr_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    cpu_data_o = '0;
    wrEn       = 1'b0;
    wrIdx      = cpuIdx;
    wrTag      = cpuTag;
    wrLine     = rdLine;
    wrDirty    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req_i && idleHit) begin
          if (cpu_wr_i) begin
            wrEn    = 1'b1;
            wrLine  = putWord(rdLine, cpuWord, cpu_data_i);
            wrDirty = 1'b1;
          end else begin
            cpu_data_o = getWord(rdLine, cpuWord);
          end
        end
      end
      WRITEBACK: begin
        mem_req_o  = 1'b1;
        mem_wr_o   = 1'b1;
        mem_addr_o = {rdTag, missIdx, 5'b00000};
        mem_data_o = rdLine;
      end
      ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {missTag, missIdx, 5'b00000};
        if (mem_ack_i) begin
          wrEn    = 1'b1;
          wrIdx   = missIdx;
          wrTag   = missTag;
          wrLine  = mem_data_i;
          wrDirty = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios then random accesses against an
// abstract cache/memory model; a bench-side memory answers line requests after nLat cycles.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_wr_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o, mem_wr_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_ack_i;

  logic         memAckDrv, spurAck;
  logic [255:0] memDataDrv, spurData;

  int checks = 0;
  int errors = 0;
  int nLat   = 3;
  int reqCycles;

  always #5 clk_i = ~clk_i;

  assign mem_ack_i  = memAckDrv | spurAck;
  assign mem_data_i = spurAck ? spurData : memDataDrv;

  dcache_controller dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_wr_i    (cpu_wr_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_wr_o    (mem_wr_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  // Main memory seen by the DUT, and the model's own independent copy.
  logic [255:0] memArr  [logic [26:0]];
  logic [255:0] refMain [logic [26:0]];

  bit           refValid [16];
  bit           refDirty [16];
  logic [26:0]  refLa    [16];
  logic [255:0] refLine  [16];

  int           lastStalls;
  logic [31:0]  lastData, lastWbAddr, lastAllocAddr;
  logic [255:0] lastWbLine;

  function automatic logic [255:0] lineInit(input logic [26:0] la);
    logic [255:0] l;
    logic [31:0]  v;
    for (int w = 0; w < 8; w++) begin
      v = {2'b00, la, 3'(w)} * 32'h9E37_79B9;
      l[w*32 +: 32] = v ^ 32'h5A5A_0000;
    end
    return l;
  endfunction

  function automatic logic [255:0] memRead(input logic [26:0] la);
    return memArr.exists(la) ? memArr[la] : lineInit(la);
  endfunction

  function automatic logic [255:0] refRead(input logic [26:0] la);
    return refMain.exists(la) ? refMain[la] : lineInit(la);
  endfunction

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", name, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      refValid[i] = 1'b0;
      refDirty[i] = 1'b0;
    end
  endtask

  task automatic modelStep(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           output int expStall, output logic expWb, output logic [31:0] expWbAddr,
                           output logic [255:0] expWbLine, output logic expMiss,
                           output logic [31:0] expAllocAddr, output logic [31:0] expData);
    logic [3:0]  idx;
    logic [26:0] la;
    logic [2:0]  w;
    idx = addr[8:5];
    la  = addr[31:5];
    w   = addr[4:2];
    expMiss      = !(refValid[idx] && refLa[idx] == la);
    expWb        = expMiss && refValid[idx] && refDirty[idx];
    expWbAddr    = {refLa[idx], 5'b00000};
    expWbLine    = refLine[idx];
    expAllocAddr = {la, 5'b00000};
    expStall     = !expMiss ? 0 : (expWb ? 2 * nLat + 1 : nLat + 1);
    if (expMiss) begin
      if (expWb) refMain[refLa[idx]] = refLine[idx];
      refLine[idx]  = refRead(la);
      refLa[idx]    = la;
      refValid[idx] = 1'b1;
      refDirty[idx] = 1'b0;
    end
    if (wr) begin
      refLine[idx][{w, 5'b00000} +: 32] = data;
      refDirty[idx] = 1'b1;
      expData = 32'h0;
    end else begin
      expData = refLine[idx][{w, 5'b00000} +: 32];
    end
  endtask

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input string tag);
    int           expStall, stalls;
    logic         expWb, expMiss, sawWb, sawAlloc, timedOut;
    logic [31:0]  expWbAddr, expAllocAddr, expData;
    logic [255:0] expWbLine;
    modelStep(wr, addr, data, expStall, expWb, expWbAddr, expWbLine, expMiss, expAllocAddr, expData);
    @(posedge clk_i); #1;
    cpu_req_i = 1'b1; cpu_wr_i = wr; cpu_addr_i = addr; cpu_data_i = data;
    stalls = 0; sawWb = 1'b0; sawAlloc = 1'b0; timedOut = 1'b0;
    lastWbAddr = '0; lastWbLine = '0; lastAllocAddr = '0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o && mem_wr_o && !sawWb) begin
        sawWb = 1'b1; lastWbAddr = mem_addr_o; lastWbLine = mem_data_o;
      end
      if (mem_req_o && !mem_wr_o && !sawAlloc) begin
        sawAlloc = 1'b1; lastAllocAddr = mem_addr_o;
      end
      if (!cpu_stall_o) break;
      stalls++;
      if (stalls > 100) begin
        timedOut = 1'b1;
        break;
      end
    end
    lastStalls = stalls;
    lastData   = cpu_data_o;
    chk({tag, ".timeout"}, timedOut, 1'b0);
    chk({tag, ".stall"}, stalls, expStall);
    chk({tag, ".data"}, cpu_data_o, expData);
    chk({tag, ".sawWb"}, sawWb, expWb);
    if (expWb) begin
      chk({tag, ".wbAddr"}, lastWbAddr, expWbAddr);
      chk({tag, ".wbLine"}, lastWbLine, expWbLine);
    end
    if (expMiss) chk({tag, ".allocAddr"}, lastAllocAddr, expAllocAddr);
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0; cpu_wr_i = 1'b0;
    #1;
    chk({tag, ".idleData"}, cpu_data_o, 32'h0);
  endtask

  // Memory responder: acks in the nLat-th consecutive cycle of a request.
  initial begin
    memAckDrv = 1'b0; memDataDrv = '0; reqCycles = 0;
    forever begin
      @(negedge clk_i);
      memAckDrv  = 1'b0;
      memDataDrv = '0;
      if (mem_req_o && !rst_i) begin
        reqCycles++;
        if (reqCycles >= nLat) begin
          reqCycles = 0;
          memAckDrv = 1'b1;
          if (mem_wr_o) memArr[mem_addr_o[31:5]] = mem_data_o;
          else          memDataDrv = memRead(mem_addr_o[31:5]);
        end
      end else begin
        reqCycles = 0;
      end
    end
  end

  initial begin
    logic [255:0] pre;
    int           eS;
    logic         eW, eM;
    logic [31:0]  eWA, eAA, eD;
    logic [255:0] eWL;
    logic [31:0]  rAddr;
    logic [22:0]  rTag;

    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_wr_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    spurAck = 1'b0; spurData = '0;
    modelReset();
    pre = lineInit(27'd2);
    pre[31:0] = 32'hAAAA_0001;
    memArr[27'd2]  = pre;
    refMain[27'd2] = pre;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst.memReq", mem_req_o, 1'b0);
    chk("rst.memWr", mem_wr_o, 1'b0);
    chk("rst.memAddr", mem_addr_o, 32'h0);
    chk("rst.memData", mem_data_o, 256'h0);
    chk("rst.stall", cpu_stall_o, 1'b0);
    chk("rst.cpuData", cpu_data_o, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    nLat = 3;
    access(1'b0, 32'h0000_0040, 32'h0, "coldLoad");
    chk("coldLoad.stall4", lastStalls, 4);
    chk("coldLoad.addr", lastAllocAddr, 32'h40);
    chk("coldLoad.word0", lastData, 32'hAAAA_0001);

    access(1'b1, 32'h0000_0044, 32'h1234_5678, "storeHit");
    chk("storeHit.noStall", lastStalls, 0);
    access(1'b0, 32'h0000_0044, 32'h0, "loadAfterStore");
    chk("loadAfterStore.word", lastData, 32'h1234_5678);

    access(1'b0, 32'h0000_0240, 32'h0, "dirtyEvict");
    chk("dirtyEvict.stall7", lastStalls, 7);
    chk("dirtyEvict.wbAddr40", lastWbAddr, 32'h40);
    chk("dirtyEvict.wbWord1", lastWbLine[63:32], 32'h1234_5678);
    chk("dirtyEvict.allocAddr", lastAllocAddr, 32'h240);

    access(1'b1, 32'h0000_0360, 32'hCAFE_F00D, "writeMiss");
    chk("writeMiss.stall4", lastStalls, 4);
    access(1'b0, 32'h0000_0360, 32'h0, "writeMissReload");
    chk("writeMissReload.word", lastData, 32'hCAFE_F00D);
    access(1'b0, 32'h0000_0560, 32'h0, "writeMissEvict");
    chk("writeMissEvict.wbAddr", lastWbAddr, 32'h360);
    chk("writeMissEvict.wbWord0", lastWbLine[31:0], 32'hCAFE_F00D);

    @(posedge clk_i); #1;
    spurAck = 1'b1; spurData = {8{32'hDEAD_BEEF}};
    @(posedge clk_i); #1;
    spurAck = 1'b0; spurData = '0;
    @(negedge clk_i);
    chk("spurAck.memReq", mem_req_o, 1'b0);
    access(1'b0, 32'h0000_0244, 32'h0, "spurAck.hit240");
    chk("spurAck.hitStall", lastStalls, 0);
    access(1'b0, 32'h0000_0560, 32'h0, "spurAck.hit560");

    // Reset two cycles into a fill of a cold line.
    @(posedge clk_i); #1;
    cpu_req_i = 1'b1; cpu_wr_i = 1'b0; cpu_addr_i = 32'h0000_0480;
    @(negedge clk_i);
    chk("rstAlloc.stall", cpu_stall_o, 1'b1);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rstAlloc.inFill", mem_req_o, 1'b1);
    chk("rstAlloc.fillAddr", mem_addr_o, 32'h480);
    @(posedge clk_i); #1;
    rst_i = 1'b1; cpu_req_i = 1'b0;
    #1;
    chk("rstAlloc.memReqDrop", mem_req_o, 1'b0);
    chk("rstAlloc.memAddr", mem_addr_o, 32'h0);
    chk("rstAlloc.stall0", cpu_stall_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    modelReset();
    access(1'b0, 32'h0000_0560, 32'h0, "afterRst.miss560");
    chk("afterRst.stall4", lastStalls, 4);
    access(1'b0, 32'h0000_0044, 32'h0, "afterRst.load44");
    chk("afterRst.word", lastData, 32'h1234_5678);

    // Request dropped mid-miss: the fill still completes.
    modelStep(1'b0, 32'h0000_0680, 32'h0, eS, eW, eWA, eWL, eM, eAA, eD);
    @(posedge clk_i); #1;
    cpu_req_i = 1'b1; cpu_wr_i = 1'b0; cpu_addr_i = 32'h0000_0680;
    @(negedge clk_i);
    chk("drop.stall", cpu_stall_o, 1'b1);
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
    repeat (2 * nLat + 4) @(posedge clk_i);
    @(negedge clk_i);
    chk("drop.memIdle", mem_req_o, 1'b0);
    access(1'b0, 32'h0000_0680, 32'h0, "drop.hit");
    chk("drop.hitStall", lastStalls, 0);

    for (int i = 0; i < 200; i++) begin
      nLat  = $urandom_range(1, 4);
      rTag  = 23'($urandom_range(0, 3));
      rAddr = {rTag, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 2'b00};
      access(1'($urandom_range(0, 1)), rAddr, $urandom, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
